// File: rtl/id_ex_pkg.sv
// Shared types and constants for the ID/EX decode-issue stage.
// Opcodes, ALU operation classes and the registered payload layout.
package id_ex_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_RTYPE = 2'b10;

  typedef struct packed {
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [1:0]      alu_op;
    logic [3:0]      func;
    logic [XLEN-1:0] rs2_data;
    logic [4:0]      rd;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            branch;
    logic            illegal;
  } id_ex_payload_t;

  function automatic logic [XLEN-1:0] sext12(input logic [11:0] imm);
    return {{(XLEN-12){imm[11]}}, imm};
  endfunction

endpackage

// File: rtl/id_ex_stage_decode.sv
// Combinational RV32 decode of one instruction plus its register operands
// into the payload registered by id_ex_stage.
module id_decode
  import id_ex_pkg::*;
(
  input  logic [31:0]     inst,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output id_ex_payload_t  payload
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [4:0] rd_field;
  logic       wants_rd;
  logic       unused_reg_fields;

  assign opcode   = inst[6:0];
  assign funct3   = inst[14:12];
  assign rd_field = inst[11:7];
  // Source register indices are resolved upstream; only their data arrives here.
  assign unused_reg_fields = ^inst[19:15];

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    payload          = '0;
    wants_rd         = 1'b0;
    payload.alu_a    = rs1;
    payload.rs2_data = rs2;
    case (opcode)
      OPC_RTYPE: begin
        payload.alu_op = ALU_OP_RTYPE;
        payload.func   = {inst[30], funct3};
        payload.alu_b  = rs2;
        wants_rd       = 1'b1;
      end
      OPC_OPIMM: begin
        payload.alu_op = ALU_OP_RTYPE;
        // inst[30] only selects SRAI vs SRLI; elsewhere it is immediate data.
        payload.func   = (funct3 == 3'b101) ? {inst[30], funct3} : {1'b0, funct3};
        payload.alu_b  = sext12(inst[31:20]);
        wants_rd       = 1'b1;
      end
      OPC_LOAD: begin
        payload.alu_op   = ALU_OP_ADD;
        payload.func     = {1'b0, funct3};
        payload.alu_b    = sext12(inst[31:20]);
        payload.mem_read = 1'b1;
        wants_rd         = 1'b1;
      end
      OPC_STORE: begin
        payload.alu_op    = ALU_OP_ADD;
        payload.func      = {1'b0, funct3};
        payload.alu_b     = sext12({inst[31:25], inst[11:7]});
        payload.mem_write = 1'b1;
      end
      OPC_BRANCH: begin
        payload.alu_op = ALU_OP_SUB;
        payload.func   = {1'b0, funct3};
        payload.alu_b  = rs2;
        payload.branch = 1'b1;
      end
      default: begin
        payload.illegal = 1'b1;
      end
    endcase
    payload.reg_write = wants_rd && (rd_field != 5'd0);
    payload.rd        = payload.reg_write ? rd_field : 5'd0;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline stage: decode plus valid/ready output register with flush.
// Define ID_EX_SKID_EN for a registered in_ready backed by one skid entry.
module id_ex_stage
  import id_ex_pkg::*;
#(
  parameter int DWIDTH = XLEN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_inst,
  input  logic [DWIDTH-1:0] in_rs1,
  input  logic [DWIDTH-1:0] in_rs2,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] alu_a,
  output logic [DWIDTH-1:0] alu_b,
  output logic [1:0]        alu_op,
  output logic [3:0]        func,
  output logic [DWIDTH-1:0] rs2_data,
  output logic [4:0]        rd,
  output logic              reg_write,
  output logic              mem_read,
  output logic              mem_write,
  output logic              branch,
  output logic              illegal
);

  id_ex_payload_t dec;
  id_ex_payload_t out_q;
  logic           out_valid_q;
  logic           accept;

  id_decode u_decode (
    .inst    (in_inst),
    .rs1     (in_rs1),
    .rs2     (in_rs2),
    .payload (dec)
  );

`ifdef ID_EX_SKID_EN
  id_ex_payload_t skid_q;
  logic           skid_valid;

  // Registered ready: the skid entry absorbs the beat that arrives in the
  // cycle out_ready drops, so out_ready never reaches in_ready.
  assign in_ready = !skid_valid;
  assign accept   = in_valid && !skid_valid && !flush;

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
      skid_valid  <= 1'b0;
      skid_q      <= '0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
      skid_valid  <= 1'b0;
    end else if (!out_valid_q || out_ready) begin
      if (skid_valid) begin
        out_q       <= skid_q;
        out_valid_q <= 1'b1;
        skid_valid  <= 1'b0;
      end else if (accept) begin
        out_q       <= dec;
        out_valid_q <= 1'b1;
      end else begin
        out_valid_q <= 1'b0;
      end
    end else if (accept) begin
      skid_q     <= dec;
      skid_valid <= 1'b1;
    end
  end
`else
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (accept) begin
      out_q       <= dec;
      out_valid_q <= 1'b1;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end
`endif

  assign out_valid = out_valid_q;
  assign alu_a     = out_q.alu_a;
  assign alu_b     = out_q.alu_b;
  assign alu_op    = out_q.alu_op;
  assign func      = out_q.func;
  assign rs2_data  = out_q.rs2_data;
  assign rd        = out_q.rd;
  assign reg_write = out_q.reg_write;
  assign mem_read  = out_q.mem_read;
  assign mem_write = out_q.mem_write;
  assign branch    = out_q.branch;
  assign illegal   = out_q.illegal;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: queue-based reference model checked
// every cycle, plus directed vectors with hand-computed literal expectations.
module tb_id_ex_stage;
  import id_ex_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [31:0] in_rs1;
  logic [31:0] in_rs2;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [1:0]  alu_op;
  logic [3:0]  func;
  logic [31:0] rs2_data;
  logic [4:0]  rd;
  logic        reg_write;
  logic        mem_read;
  logic        mem_write;
  logic        branch;
  logic        illegal;

  int total = 0;
  int bad   = 0;
  int n_out = 0;

  id_ex_payload_t q[$];
  id_ex_payload_t act;
  id_ex_payload_t prev;
  logic           prev_stall = 1'b0;

  id_ex_stage #(.DWIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_inst   (in_inst),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .func      (func),
    .rs2_data  (rs2_data),
    .rd        (rd),
    .reg_write (reg_write),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .branch    (branch),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] actual, input logic [127:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Reference decode written from the instruction-format rules.
  function automatic id_ex_payload_t model(input logic [31:0] inst, input logic [31:0] rs1,
                                           input logic [31:0] rs2);
    id_ex_payload_t   p;
    logic signed [31:0] si;
    logic [31:0]      imm_i;
    logic [31:0]      imm_s;
    logic [6:0]       opc;
    logic [2:0]       f3;
    bit               wants_rd;
    si       = inst;
    imm_i    = 32'(si >>> 20);
    imm_s    = {imm_i[31:5], inst[11:7]};
    opc      = inst[6:0];
    f3       = inst[14:12];
    wants_rd = 0;
    p        = '0;
    p.alu_a    = rs1;
    p.rs2_data = rs2;
    if (opc == 7'h33) begin
      p.alu_op = 2'd2; p.func = {inst[30], f3}; p.alu_b = rs2; wants_rd = 1;
    end else if (opc == 7'h13) begin
      p.alu_op = 2'd2; p.alu_b = imm_i; wants_rd = 1;
      p.func = (f3 == 3'd5) ? {inst[30], f3} : {1'b0, f3};
    end else if (opc == 7'h03) begin
      p.alu_op = 2'd0; p.func = {1'b0, f3}; p.alu_b = imm_i; p.mem_read = 1; wants_rd = 1;
    end else if (opc == 7'h23) begin
      p.alu_op = 2'd0; p.func = {1'b0, f3}; p.alu_b = imm_s; p.mem_write = 1;
    end else if (opc == 7'h63) begin
      p.alu_op = 2'd1; p.func = {1'b0, f3}; p.alu_b = rs2; p.branch = 1;
    end else begin
      p.illegal = 1;
    end
    p.reg_write = wants_rd && (inst[11:7] != 5'd0);
    p.rd        = p.reg_write ? inst[11:7] : 5'd0;
    return p;
  endfunction

  // Compare process: outputs are sampled mid-cycle, then the model advances
  // by the handshakes that the coming rising edge will perform.
  always @(negedge clk) begin
    act.alu_a     = alu_a;
    act.alu_b     = alu_b;
    act.alu_op    = alu_op;
    act.func      = func;
    act.rs2_data  = rs2_data;
    act.rd        = rd;
    act.reg_write = reg_write;
    act.mem_read  = mem_read;
    act.mem_write = mem_write;
    act.branch    = branch;
    act.illegal   = illegal;
    if (!rst_n) begin
      q.delete();
      prev_stall = 1'b0;
      check("reset_out_valid", out_valid, 1'b0);
      check("reset_in_ready", in_ready, 1'b1);
      check("reset_payload", act, '0);
    end else begin
      check("out_valid", out_valid, q.size() != 0);
`ifdef ID_EX_SKID_EN
      check("in_ready", in_ready, q.size() < 2);
`else
      check("in_ready", in_ready, (q.size() == 0) || out_ready);
`endif
      if (out_valid && q.size() != 0) check("payload", act, q[0]);
      if (prev_stall && out_valid) check("stall_stable", act, prev);
      prev_stall = out_valid && !out_ready;
      prev       = act;
      if (out_valid && out_ready && q.size() != 0) begin
        void'(q.pop_front());
        n_out++;
      end
      if (flush) q.delete();
      if (in_valid && in_ready && !flush) q.push_back(model(in_inst, in_rs1, in_rs2));
    end
  end

  // One beat into an empty stage with out_ready high; returns mid-cycle
  // after the accepting edge, when the beat is on the outputs.
  task automatic send1(input logic [31:0] inst, input logic [31:0] rs1, input logic [31:0] rs2);
    @(posedge clk); #1;
    in_inst = inst; in_rs1 = rs1; in_rs2 = rs2; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  // Hold a beat until the stage takes it, with a bounded wait.
  task automatic beat(input logic [31:0] inst, input logic [31:0] rs1, input logic [31:0] rs2);
    bit ok;
    ok = 0;
    in_inst = inst; in_rs1 = rs1; in_rs2 = rs2; in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk); #1;
      if (ok) break;
    end
    check("beat_accepted", ok, 1'b1);
  endtask

  task automatic drive_cycle(input logic v, input logic [31:0] inst, input logic fl, input logic ordy);
    in_valid = v; in_inst = inst; in_rs1 = inst ^ 32'h5A5A_0000; in_rs2 = ~inst;
    flush = fl; out_ready = ordy;
    @(posedge clk); #1;
  endtask

  id_ex_payload_t mp;
  int n0;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_inst = '0; in_rs1 = '0; in_rs2 = '0;
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Pin the model against hand-decoded words.
    mp = model(32'h40208033, 32'd7, 32'd3);
    check("model_sub_func", mp.func, 4'b1000);
    mp = model(32'hFFC12083, 32'h100, 32'd0);
    check("model_lw_imm", mp.alu_b, 32'hFFFF_FFFC);
    mp = model(32'h0020A423, 32'd0, 32'd0);
    check("model_sw_imm", mp.alu_b, 32'd8);
    mp = model(32'h0000007F, 32'd0, 32'd0);
    check("model_illegal", {mp.illegal, mp.reg_write}, 2'b10);

    // sub x0, x1, x2
    send1(32'h40208033, 32'd7, 32'd3);
    check("sub_valid", out_valid, 1'b1);
    check("sub_alu_op", alu_op, 2'b10);
    check("sub_func", func, 4'b1000);
    check("sub_alu_a", alu_a, 32'd7);
    check("sub_alu_b", alu_b, 32'd3);
    check("sub_reg_write", reg_write, 1'b0);
    check("sub_rd", rd, 5'd0);

    // lw x1, -4(x2)
    send1(32'hFFC12083, 32'h100, 32'd0);
    check("lw_alu_b", alu_b, 32'hFFFF_FFFC);
    check("lw_alu_op", alu_op, 2'b00);
    check("lw_mem_read", mem_read, 1'b1);
    check("lw_rd", rd, 5'd1);
    check("lw_reg_write", reg_write, 1'b1);

    // sw x2, 8(x1)
    send1(32'h0020A423, 32'h40, 32'hDEAD_BEEF);
    check("sw_alu_b", alu_b, 32'd8);
    check("sw_mem_write", mem_write, 1'b1);
    check("sw_rs2_data", rs2_data, 32'hDEAD_BEEF);
    check("sw_reg_write", {reg_write, rd}, 6'd0);

    // beq x1, x2, 8
    send1(32'h00208463, 32'd5, 32'd5);
    check("beq_alu_op", alu_op, 2'b01);
    check("beq_branch", branch, 1'b1);
    check("beq_reg_write", reg_write, 1'b0);

    // srai x3, x1, 5 keeps inst[30]; addi x5, x1, 0x400 must not
    send1(32'h4050D193, 32'h80, 32'd0);
    check("srai_func", func, 4'b1101);
    check("srai_rd", rd, 5'd3);
    send1(32'h40008293, 32'h1, 32'd0);
    check("addi_func", func, 4'b0000);
    check("addi_alu_b", alu_b, 32'h400);
    check("addi_reg_write", reg_write, 1'b1);

    // Unknown opcode
    send1(32'h0000007F, 32'd9, 32'd0);
    check("ill_illegal", illegal, 1'b1);
    check("ill_ctrl", {reg_write, mem_read, mem_write, branch, alu_op}, 6'd0);

    // Backpressure: four distinct beats, out_ready low three cycles mid-stream
    @(posedge clk); #1;
    n0 = n_out;
    out_ready = 1'b1;
    fork
      begin
        beat(32'h00108093, 32'd10, 32'd0);
        beat(32'h00208113, 32'd20, 32'd0);
        beat(32'h002081B3, 32'd30, 32'd4);
        beat(32'hFFF08213, 32'd40, 32'd0);
        in_valid = 1'b0;
      end
      begin
        repeat (2) begin @(posedge clk); #1; end
        out_ready = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        out_ready = 1'b1;
      end
    join
    repeat (6) begin @(posedge clk); #1; end
    check("bp_delivered", n_out - n0, 4);
    check("bp_queue_empty", q.size(), 0);

    // Flush: stall with beats held, then flush alongside a new beat
    n0 = n_out;
    drive_cycle(1'b1, 32'h00A00513, 1'b0, 1'b0);
    drive_cycle(1'b1, 32'h00B00593, 1'b0, 1'b0);
    drive_cycle(1'b1, 32'h00C00613, 1'b1, 1'b0);
    drive_cycle(1'b0, 32'h0, 1'b0, 1'b1);
    check("flush_out_valid", out_valid, 1'b0);
    check("flush_in_ready", in_ready, 1'b1);
    // Flush on an empty, ready stage still discards the offered beat
    drive_cycle(1'b1, 32'h00D00693, 1'b1, 1'b1);
    drive_cycle(1'b0, 32'h0, 1'b0, 1'b1);
    check("flush_empty_out_valid", out_valid, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    check("flush_none_delivered", n_out - n0, 0);

    // Asynchronous reset while stalled
    drive_cycle(1'b1, 32'h00E00713, 1'b0, 1'b0);
    in_valid = 1'b0;
    check("pre_rst_out_valid", out_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", out_valid, 1'b0);
    check("async_rst_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    send1(32'h00F00793, 32'd3, 32'd0);
    check("post_rst_valid", out_valid, 1'b1);
    check("post_rst_rd", rd, 5'd15);

    repeat (3) @(negedge clk);
    check("final_queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode/issue pipeline stage that sits directly upstream of the ALU and its control decoder. It accepts one RV32 instruction per handshake along with its register-file operands. It decodes the instruction into `alu_op`, `func`, the selected ALU operands and the memory/writeback control bits, then registers the result for the execute stage. Flow control uses valid/ready in both directions, and a synchronous flush removes wrong-path instructions.

## Interface
- `DWIDTH`, 32: datapath width for operands and immediates.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  upstream beat valid.
- `in_ready`  out  1  stage can accept a beat.
- `in_inst`  in  32  instruction word.
- `in_rs1`, `in_rs2`  in  DWIDTH  register-file read data.
- `flush`  in  1  synchronous kill of all held beats.
- `out_valid`  out  1  registered beat valid toward the ALU.
- `out_ready`  in  1  execute stage accepts the beat.
- `alu_a`, `alu_b`  out  DWIDTH  ALU operands A and B.
- `alu_op`  out  2  00 = add (load/store), 01 = sub (branch), 10 = R/I-type.
- `func`  out  4  {func bit, funct3} for the ALU control decoder.
- `rs2_data`  out  DWIDTH  store data.
- `rd`  out  5  destination register.
- `reg_write`, `mem_read`, `mem_write`, `branch`, `illegal`  out  1 each  control bits.

## Operation
Decode rules (opcode = `inst[6:0]`):
- **0110011 (R-type):** `alu_op` = 10, `func` = {inst[30], funct3}, B = rs2, `reg_write` = 1.
- **0010011 (OP-IMM):** `alu_op` = 10, B = sign-extended I-immediate, `reg_write` = 1.
  - `func` = {inst[30], funct3} when funct3 = 101.
  - `func` = {0, funct3} otherwise.
- **0000011 (load):** `alu_op` = 00, B = I-immediate, `mem_read` = 1, `reg_write` = 1.
- **0100011 (store):** `alu_op` = 00, B = S-immediate {inst[31:25], inst[11:7]}, `mem_write` = 1, `reg_write` = 0.
- **1100011 (branch):** `alu_op` = 01, B = rs2, `branch` = 1, `reg_write` = 0.
- **Any other opcode:** `illegal` = 1, `alu_op` = 00, all other control bits = 0. The beat still propagates.

Operand and width rules:
- `alu_a` = rs1 for every instruction.
- Immediates are sign-extended from bit 31 to DWIDTH.
- `rd` = inst[11:7] when `reg_write` = 1, else 0.
- `reg_write` is also forced to 0 when rd = 0.

Transfer rules:
- Input transfer occurs when `in_valid` and `in_ready` are both high.
- Output transfer occurs when `out_valid` and `out_ready` are both high.
- Beats leave in the order they were accepted. No beat is dropped except by flush.

## Timing
- **Reset:**
  - All payload outputs and `out_valid` = 0.
  - `in_ready` = 1.
  - Skid entry empty.
- **Latency:** 1 cycle. A beat accepted at edge N is presented with `out_valid` = 1 after edge N.
- **Throughput:** one beat per cycle while `out_ready` stays high.
- **Stability:** while `out_valid` = 1 and `out_ready` = 0, all outputs hold stable.
- **Flush:**
  - At the next edge, `out_valid` = 0 and the skid entry is cleared.
  - A beat presented in the same cycle as `flush` is discarded, even if `in_ready` = 1.
  - `in_ready` = 1 in the cycle after the flush.
- **Flush with output transfer in the same cycle:** the transfer completes; the downstream beat is the consumer's responsibility.
- **Reset mid-transfer:** reset returns immediately to the reset values. In-flight beats are lost.

## Configuration
`ID_EX_SKID_EN`:
- **Defined:** two-entry buffer (output register plus skid register).
  - `in_ready` is a register: high exactly when the skid entry is empty.
  - When `out_ready` drops while a new beat is accepted, that beat parks in the skid entry.
  - The parked beat moves to the output register on the next output transfer.
  - No combinational path from `out_ready` to `in_ready`.
- **Undefined:** single output register only.
  - `in_ready` = !`out_valid` || `out_ready`, which is combinational.
  - Same latency and throughput.

## Structure
- **Package `id_ex_pkg`:**
  - Opcode constants: OPC_RTYPE, OPC_OPIMM, OPC_LOAD, OPC_STORE, OPC_BRANCH.
  - ALU_OP_ADD/SUB/RTYPE 2-bit constants.
  - A packed struct `id_ex_payload_t` holding every output except the handshake signals.
- **Sub-module `id_decode`:** purely combinational; maps inst + rs1 + rs2 to `id_ex_payload_t`.
- The top level holds the handshake and buffer registers.

## Test plan
- **R-type SUB:** inst 0x40208033 (sub x0, x1, x2), rs1 = 7, rs2 = 3 → one cycle later `out_valid` = 1, `alu_op` = 10, `func` = 1000, `alu_b` = 3, `reg_write` = 0 (rd = 0).
- **Load:** inst 0xFFC12083 (lw x1, -4(x2)), rs1 = 0x100 → `alu_b` = 0xFFFFFFFC, `alu_op` = 00, `mem_read` = 1, `rd` = 1.
- **Store / branch:**
  - inst 0x0020A423 (sw x2, 8(x1)) → `alu_b` = 8, `mem_write` = 1, `rs2_data` = in_rs2.
  - inst 0x00208463 (beq) → `alu_op` = 01, `branch` = 1.
- **Backpressure:** stream 4 beats with `out_ready` low for 3 cycles mid-stream → all 4 arrive in order, outputs stable while stalled, no duplicates. With `ID_EX_SKID_EN` defined, `in_ready` falls exactly one cycle after the stall begins.
- **Flush:** 2 beats held plus `flush` = 1 together with `in_valid` = 1 → next cycle `out_valid` = 0, `in_ready` = 1, and none of the 3 beats ever appear.
- **Illegal and reset:** inst 0x0000007F → `illegal` = 1, `reg_write` = 0. Asserting `rst_n` = 0 mid-stall clears `out_valid` without waiting for a clock edge.
